// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_state_t : FILL (pipeline refill / bubble), RUN (streaming),
//                     HALT (self-loop detected; only reachable when the
//                     FETCH_HALT_DETECT_EN macro is defined)
//   - WORD_BYTES    : byte stride between consecutive instructions
//   - HALT_INSTR    : encoding of "beq x0,x0,0", the canonical self-loop
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0063;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
//   Bundle between the fetch stage and the control decoder.
//   Signals:
//     en          decoder -> fetch   1 = advance, 0 = stall
//     PCsrc       decoder -> fetch   redirect request for the instruction on instr_o
//     ImmOp       decoder -> fetch   branch offset in bytes, added to pc_o
//     instr_o     fetch -> decoder   fetched instruction
//     pc_o        fetch -> decoder   byte address of instr_o
//     instr_valid fetch -> decoder   instr_o/pc_o hold a real instruction
//     halted      fetch -> decoder   self-loop detected
//   Modports:
//     master  decoder side (drives en/PCsrc/ImmOp)
//     slave   fetch side (drives the instruction outputs)
// -----------------------------------------------------------------------------
interface fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  en;
    logic                  PCsrc;
    logic [ADDR_WIDTH-1:0] ImmOp;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  instr_valid;
    logic                  halted;

    modport master (
        output en, PCsrc, ImmOp,
        input  instr_o, pc_o, instr_valid, halted
    );

    modport slave (
        input  en, PCsrc, ImmOp,
        output instr_o, pc_o, instr_valid, halted
    );

endinterface

// File: rtl/instr_rom.sv
// -----------------------------------------------------------------------------
// instr_rom
//   Word-addressed instruction ROM with a one-cycle synchronous read.
//   The memory image is supplied by the environment that instantiates it
//   (for example written into mem before the first read); ROM_FILE is kept
//   as a descriptive parameter only.
//   Ports:
//     clk   in   clock
//     en    in   1 = capture mem[addr] into dout on this edge, 0 = dout holds
//     addr  in   word index
//     dout  out  registered read data
// -----------------------------------------------------------------------------
module instr_rom #(
    parameter int    ROM_AW     = 8,
    parameter int    DATA_WIDTH = 32,
    parameter string ROM_FILE   = "program.hex"
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ROM_AW-1:0]     addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ROM_AW)-1];

    // Read port: only advances when the fetch stage actually consumes a word,
    // so dout doubles as the held instruction during stalls and bubbles.
    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the reduced RISC-V core. Owns the PC and the
//   instruction ROM, streams one instruction per cycle to the decoder and
//   redirects on taken branches at the cost of one bubble.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   synchronous active-high reset
//     bus   fetch_if.slave: en, PCsrc, ImmOp in; instr_o, pc_o, instr_valid,
//           halted out
//   Configuration:
//     FETCH_HALT_DETECT_EN  when defined, a valid HALT_INSTR on instr_o sends
//                           the stage into HALT (frozen until reset) instead
//                           of being treated as a branch; otherwise halted
//                           is tied low.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ROM_AW     = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter string                 ROM_FILE   = "program.hex"
) (
    input logic   clk,
    input logic   rst,
    fetch_if.slave bus
);

    fetch_state_t          state_q;
    logic [ADDR_WIDTH-1:0] fetchPc_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  valid_q;
    logic                  romLoaded_q;
    logic [DATA_WIDTH-1:0] romData;
    logic                  loadNow;
    logic                  redirect;
    logic                  haltNow;
    logic                  romEn;

    // The ROM output register is the instruction register. It has no reset,
    // so romLoaded_q masks it to zero until the first read after reset.
    assign romEn = bus.en & ~rst & loadNow;

    instr_rom #(
        .ROM_AW     (ROM_AW),
        .DATA_WIDTH (DATA_WIDTH),
        .ROM_FILE   (ROM_FILE)
    ) uRom (
        .clk  (clk),
        .en   (romEn),
        .addr (fetchPc_q[ROM_AW+1:2]),
        .dout (romData)
    );

    assign bus.instr_o     = romLoaded_q ? romData : '0;
    assign bus.pc_o        = pc_q;
    assign bus.instr_valid = valid_q;

    // Decide what the next enabled edge does: fetch the next word, take a
    // redirect, or enter HALT. PCsrc only matters in RUN, where the
    // instruction on the outputs is always valid.
    always_comb begin
        loadNow  = 1'b0;
        redirect = 1'b0;
        haltNow  = 1'b0;
        case (state_q)
            FILL: loadNow = 1'b1;
            RUN: begin
`ifdef FETCH_HALT_DETECT_EN
                if (valid_q && (bus.instr_o == DATA_WIDTH'(HALT_INSTR))) begin
                    haltNow = 1'b1;
                end else
`endif
                if (bus.PCsrc) begin
                    redirect = 1'b1;
                end else begin
                    loadNow = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // PC datapath and FSM. Reset wins over everything; en=0 freezes every
    // register. A redirect keeps pc_o/instr_o as they are and drops valid,
    // so the following FILL edge brings in the branch target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            fetchPc_q   <= RESET_PC;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            romLoaded_q <= 1'b0;
        end else if (bus.en) begin
            if (loadNow) begin
                pc_q        <= fetchPc_q;
                fetchPc_q   <= fetchPc_q + ADDR_WIDTH'(WORD_BYTES);
                valid_q     <= 1'b1;
                romLoaded_q <= 1'b1;
                state_q     <= RUN;
            end else if (redirect) begin
                fetchPc_q <= pc_q + bus.ImmOp;
                valid_q   <= 1'b0;
                state_q   <= FILL;
            end else if (haltNow) begin
                state_q <= HALT;
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q;

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (bus.en && haltNow) begin
            halted_q <= 1'b1;
        end
    end

    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed self-checking bench for fetch_unit. The ROM image is written
//   directly into the ROM array (ROM_FILE is left empty); word i holds
//   32'hA000_0000 + i unless a scenario overrides it.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ROM_AW     (8),
        .RESET_PC   (32'h0000_0000),
        .ROM_FILE   ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] romWord(input int idx);
        return 32'hA000_0000 + 32'(idx);
    endfunction

    // Drive all inputs at once, between clock edges.
    task automatic applyStimulus(input logic r, input logic e, input logic p,
                                 input logic [31:0] imm);
        rst       = r;
        bus.en    = e;
        bus.PCsrc = p;
        bus.ImmOp = imm;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expectState(input string tag, input logic v,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic h);
        checkOutput({tag, ".valid"},  32'(bus.instr_valid), 32'(v));
        checkOutput({tag, ".pc"},     bus.pc_o,             pc);
        checkOutput({tag, ".instr"},  bus.instr_o,          ins);
        checkOutput({tag, ".halted"}, 32'(bus.halted),      32'(h));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) begin
            dut.uRom.mem[i] = romWord(i);
        end

        // Reset held for two edges.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        expectState("reset", 1'b0, 32'h0, 32'h0, 1'b0);

        // Sequential streaming after reset.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("seq0", 1'b1, 32'h0, romWord(0), 1'b0);
        tick(); expectState("seq1", 1'b1, 32'h4, romWord(1), 1'b0);
        tick(); expectState("seq2", 1'b1, 32'h8, romWord(2), 1'b0);

        // Forward taken branch from 0x8 by +0x10.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10);
        tick(); expectState("fwd_bubble", 1'b0, 32'h8, romWord(2), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("fwd_tgt", 1'b1, 32'h18, romWord(6), 1'b0);
        tick(); expectState("fwd_tgt1", 1'b1, 32'h1C, romWord(7), 1'b0);
        tick(); expectState("fwd_tgt2", 1'b1, 32'h20, romWord(8), 1'b0);

        // Backward branch from 0x20 by -0x10.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0);
        tick(); expectState("bwd_bubble", 1'b0, 32'h20, romWord(8), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("bwd_tgt", 1'b1, 32'h10, romWord(4), 1'b0);
        tick(); expectState("bwd_tgt1", 1'b1, 32'h14, romWord(5), 1'b0);

        // Stall for three cycles with PCsrc toggling.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        tick(); expectState("stall0", 1'b1, 32'h14, romWord(5), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h40);
        tick(); expectState("stall1", 1'b1, 32'h14, romWord(5), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        tick(); expectState("stall2", 1'b1, 32'h14, romWord(5), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("resume", 1'b1, 32'h18, romWord(6), 1'b0);

        // PCsrc held high through the bubble must be ignored while refilling.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8);
        tick(); expectState("hold_bubble", 1'b0, 32'h18, romWord(6), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        tick(); expectState("hold_tgt", 1'b1, 32'h20, romWord(8), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("hold_next", 1'b1, 32'h24, romWord(9), 1'b0);

        // Reset again, then branch from 0x0 by -4 to wrap the address space.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick(); expectState("reset2", 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("wrap_seq0", 1'b1, 32'h0, romWord(0), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(); expectState("wrap_bubble", 1'b0, 32'h0, romWord(0), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("wrap_tgt", 1'b1, 32'hFFFF_FFFC, romWord(255), 1'b0);
        tick(); expectState("wrap_zero", 1'b1, 32'h0, romWord(0), 1'b0);
        tick(); expectState("wrap_four", 1'b1, 32'h4, romWord(1), 1'b0);

        // Reset asserted on the redirect edge discards the branch.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        tick(); expectState("rst_branch", 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("rst_seq0", 1'b1, 32'h0, romWord(0), 1'b0);
        tick(); expectState("rst_seq1", 1'b1, 32'h4, romWord(1), 1'b0);
        tick(); expectState("rst_seq2", 1'b1, 32'h8, romWord(2), 1'b0);

        // Self-loop at 0xC.
        dut.uRom.mem[3] = 32'h0000_0063;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick(); expectState("reset3", 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick(); expectState("loop_seq0", 1'b1, 32'h0, romWord(0), 1'b0);
        tick(); expectState("loop_seq1", 1'b1, 32'h4, romWord(1), 1'b0);
        tick(); expectState("loop_seq2", 1'b1, 32'h8, romWord(2), 1'b0);
        tick(); expectState("loop_seq3", 1'b1, 32'hC, 32'h0000_0063, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
`ifdef FETCH_HALT_DETECT_EN
        tick(); expectState("halt_enter", 1'b1, 32'hC, 32'h0000_0063, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(); expectState("halt_hold", 1'b1, 32'hC, 32'h0000_0063, 1'b1);
        end
`else
        for (int i = 0; i < 2; i++) begin
            tick(); expectState("loop_bubble", 1'b0, 32'hC, 32'h0000_0063, 1'b0);
            tick(); expectState("loop_again", 1'b1, 32'hC, 32'h0000_0063, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
